// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional misaligned-redirect trap is enabled with FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN_DEF = 32;
    localparam int unsigned PC_STEP  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4,
        FAULT = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of redirect, imem and decode-side signals of the fetch unit.
// master = fetch unit, slave = surrounding pipeline / memory / testbench.
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned ILEN = ILEN_DEF
);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] pc_out;
    logic            fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_out, inst_pc, pc_out, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_out, inst_pc, pc_out, fetch_fault
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: async reset to RESET_PC, redirect load has priority over +PC_STEP.
// Increment wraps modulo 2^XLEN.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: one outstanding imem request, one-entry output buffer.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects trap into FAULT instead of being aligned.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     ILEN     = ILEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    fetch_state_e    r_state;
    logic            r_req;
    logic            r_valid;
    logic [ILEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_fault;

    logic [XLEN-1:0] w_fetch_pc;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_misalign;
    logic            w_pc_inc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_outstanding;
    logic w_pending;

    assign w_redirect_pc = bus.redirect_pc;
    assign w_misalign    = (bus.redirect_pc[1:0] != 2'b00);

    // A request granted before the trap may still answer while in FAULT;
    // leaving FAULT must drain it so it is not taken as the new fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= 1'b0;
        end else if ((r_state == REQ) && bus.imem_gnt) begin
            r_outstanding <= 1'b1;
        end else if (bus.imem_rvalid) begin
            r_outstanding <= 1'b0;
        end
    end

    assign w_pending = r_outstanding && !bus.imem_rvalid;
`else
    assign w_redirect_pc = bus.redirect_pc & ~XLEN'(PC_STEP - 1);
    assign w_misalign    = 1'b0;
`endif

    assign w_pc_inc = (r_state == WAIT) && bus.imem_rvalid;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (bus.redirect_valid),
        .i_load_pc (w_redirect_pc),
        .i_inc     (w_pc_inc),
        .o_pc      (w_fetch_pc)
    );

    // Redirect overrides everything; a HOLD handshake in the same cycle simply
    // completes because the buffer is dropped either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_fault   <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_valid <= 1'b0;
            if (w_misalign) begin
                r_state <= FAULT;
                r_req   <= 1'b0;
                r_fault <= 1'b1;
            end else begin
                r_fault <= 1'b0;
                case (r_state)
                    REQ: begin
                        r_state <= bus.imem_gnt ? DRAIN : REQ;
                        r_req   <= !bus.imem_gnt;
                    end
                    WAIT, DRAIN: begin
                        r_state <= bus.imem_rvalid ? REQ : DRAIN;
                        r_req   <= bus.imem_rvalid;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    FAULT: begin
                        r_state <= w_pending ? DRAIN : REQ;
                        r_req   <= !w_pending;
                    end
`endif
                    default: begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                endcase
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_inst    <= bus.imem_rdata;
                        r_inst_pc <= w_fetch_pc;
                        r_valid   <= 1'b1;
                        r_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.inst_ready) begin
                        r_valid <= 1'b0;
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rvalid) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = w_fetch_pc;
    assign bus.inst_valid  = r_valid;
    assign bus.inst_out    = r_inst;
    assign bus.inst_pc     = r_inst_pc;
    assign bus.pc_out      = w_fetch_pc;
    assign bus.fetch_fault = r_fault;

endmodule
